// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / stall controller.
// Holds the controller state enum, register-address width and the r0 constant.
package hazard_stall_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MC_STALL = 2'd2,
    BR_FLUSH = 2'd3
  } hz_state_e;

  // Largest of the three cycle parameters; sizes the shared down-counter.
  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of decode/execute hazard inputs and pipeline control outputs.
// master = pipeline side driving hazard info, slave = the stall controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              id_mc_op;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              beq_taken;
  logic              pc_w_enable;
  logic              ifid_w_enable;
  logic              ifid_flush;
  logic              buble_mux_ctrl;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_mc_op, ex_rd, ex_mem_read, beq_taken,
    input  pc_w_enable, ifid_w_enable, ifid_flush, buble_mux_ctrl, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_mc_op, ex_rd, ex_mem_read, beq_taken,
    output pc_w_enable, ifid_w_enable, ifid_flush, buble_mux_ctrl, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / multi-cycle / taken-branch hazard controller driving PC and IF/ID
// enables, IF/ID flush and the ID/EX bubble-mux select (1 = pass, 0 = bubble).
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW       = hazard_stall_ctrl_pkg::REG_AW,
  parameter int LU_STALL_CYC = 1,
  parameter int BR_FLUSH_CYC = 1,
  parameter int MC_LAT       = 3,
  parameter int PERF_W       = 16
) (
  input logic             clk,
  input logic             rst_n,
  hazard_stall_ctrl_if.slave hz
);

  localparam int CNT_W = $clog2(max_of3(LU_STALL_CYC, BR_FLUSH_CYC, MC_LAT)) + 1;

  hz_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PERF_W-1:0] r_stall_cnt;

  hz_state_e        w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_lu_haz;
  logic             w_pc_we;
  logic             w_ifid_we;
  logic             w_flush;
  logic             w_buble;

  assign w_lu_haz = hz.ex_mem_read & (hz.ex_rd != REG_ZERO) &
                    ((hz.ex_rd == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rd == hz.id_rt)));

  // Next-state and Mealy output decode; a taken branch overrides any stall.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pc_we      = 1'b1;
    w_ifid_we    = 1'b1;
    w_flush      = 1'b0;
    w_buble      = 1'b1;
    if (hz.beq_taken) begin
      w_flush = 1'b1;
      w_buble = 1'b0;
      if (BR_FLUSH_CYC > 1) begin
        w_next_state = BR_FLUSH;
        w_next_cnt   = CNT_W'(BR_FLUSH_CYC - 2);
      end else begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_lu_haz) begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_buble   = 1'b0;
            if (LU_STALL_CYC > 1) begin
              w_next_state = LU_STALL;
              w_next_cnt   = CNT_W'(LU_STALL_CYC - 2);
            end else begin
              w_next_state = IDLE;
              w_next_cnt   = '0;
            end
          end else if (hz.id_mc_op) begin
            w_next_state = MC_STALL;
            w_next_cnt   = CNT_W'(MC_LAT - 2);
          end else begin
            w_next_state = IDLE;
          end
        end
        LU_STALL, MC_STALL: begin
          w_pc_we   = 1'b0;
          w_ifid_we = 1'b0;
          w_buble   = 1'b0;
          if (r_cnt == '0) begin
            w_next_state = IDLE;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        BR_FLUSH: begin
          w_flush = 1'b1;
          w_buble = 1'b0;
          if (r_cnt == '0) begin
            w_next_state = IDLE;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // State, countdown and saturating bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (!w_buble && (r_stall_cnt != {PERF_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  // While reset is held the pipeline is frozen with IF/ID cleared and bubbles inserted.
  assign hz.pc_w_enable    = rst_n & w_pc_we;
  assign hz.ifid_w_enable  = rst_n & w_ifid_we;
  assign hz.ifid_flush     = ~rst_n | w_flush;
  assign hz.buble_mux_ctrl = rst_n & w_buble;
  assign hz.stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized + directed bench for hazard_stall_ctrl; two parameter sets share stimulus
// and are compared every cycle against a cycle-count reference model.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, id_mc_op, ex_mem_read, beq_taken;

  int vectors = 0;
  int miscompares = 0;

  // Reference model per instance: remaining hold / extra flush cycles and bubble count.
  int p_lu[2]  = '{1, 3};
  int p_br[2]  = '{1, 2};
  int p_mc[2]  = '{3, 4};
  int p_max[2] = '{65535, 15};
  int hold_left[2]  = '{0, 0};
  int flush_left[2] = '{0, 0};
  int scnt[2]       = '{0, 0};

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_AW(5), .PERF_W(16)) ifa ();
  hazard_stall_ctrl_if #(.REG_AW(5), .PERF_W(4))  ifb ();

  assign ifa.id_rs = id_rs;            assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;            assign ifb.id_rt = id_rt;
  assign ifa.id_uses_rt = id_uses_rt;  assign ifb.id_uses_rt = id_uses_rt;
  assign ifa.id_mc_op = id_mc_op;      assign ifb.id_mc_op = id_mc_op;
  assign ifa.ex_rd = ex_rd;            assign ifb.ex_rd = ex_rd;
  assign ifa.ex_mem_read = ex_mem_read; assign ifb.ex_mem_read = ex_mem_read;
  assign ifa.beq_taken = beq_taken;    assign ifb.beq_taken = beq_taken;

  hazard_stall_ctrl #(.REG_AW(5), .LU_STALL_CYC(1), .BR_FLUSH_CYC(1), .MC_LAT(3), .PERF_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa.slave));
  hazard_stall_ctrl #(.REG_AW(5), .LU_STALL_CYC(3), .BR_FLUSH_CYC(2), .MC_LAT(4), .PERF_W(4))
    dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb.slave));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    logic e_pc, e_if, e_fl, e_bu, lu;
    logic [31:0] a_pc, a_if, a_fl, a_bu, a_sc;
    for (int i = 0; i < 2; i++) begin
      lu = ex_mem_read && (ex_rd != 5'd0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      if (!rst_n) begin
        {e_pc, e_if, e_fl, e_bu} = 4'b0010;
        hold_left[i] = 0; flush_left[i] = 0; scnt[i] = 0;
      end else if (beq_taken) begin
        {e_pc, e_if, e_fl, e_bu} = 4'b1110;
        flush_left[i] = p_br[i] - 1; hold_left[i] = 0;
      end else if (flush_left[i] > 0) begin
        {e_pc, e_if, e_fl, e_bu} = 4'b1110;
        flush_left[i]--;
      end else if (hold_left[i] > 0) begin
        {e_pc, e_if, e_fl, e_bu} = 4'b0000;
        hold_left[i]--;
      end else if (lu) begin
        {e_pc, e_if, e_fl, e_bu} = 4'b0000;
        hold_left[i] = p_lu[i] - 1;
      end else if (id_mc_op) begin
        {e_pc, e_if, e_fl, e_bu} = 4'b1101;
        hold_left[i] = p_mc[i] - 1;
      end else begin
        {e_pc, e_if, e_fl, e_bu} = 4'b1101;
      end
      if (i == 0) begin
        a_pc = 32'(ifa.pc_w_enable); a_if = 32'(ifa.ifid_w_enable);
        a_fl = 32'(ifa.ifid_flush);  a_bu = 32'(ifa.buble_mux_ctrl); a_sc = 32'(ifa.stall_cnt);
      end else begin
        a_pc = 32'(ifb.pc_w_enable); a_if = 32'(ifb.ifid_w_enable);
        a_fl = 32'(ifb.ifid_flush);  a_bu = 32'(ifb.buble_mux_ctrl); a_sc = 32'(ifb.stall_cnt);
      end
      check_val($sformatf("%s[%0d].pc_we", tag, i), a_pc, 32'(e_pc));
      check_val($sformatf("%s[%0d].ifid_we", tag, i), a_if, 32'(e_if));
      check_val($sformatf("%s[%0d].flush", tag, i), a_fl, 32'(e_fl));
      check_val($sformatf("%s[%0d].buble", tag, i), a_bu, 32'(e_bu));
      check_val($sformatf("%s[%0d].stall_cnt", tag, i), a_sc, 32'(scnt[i]));
      if (rst_n && !e_bu && scnt[i] < p_max[i]) scnt[i]++;
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mc, input logic [4:0] rd, input logic mr,
                      input logic beq);
    @(posedge clk);
    #1;
    rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_mc_op = mc;
    ex_rd = rd; ex_mem_read = mr; beq_taken = beq;
    @(negedge clk);
    check_cycle(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_mc_op = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; beq_taken = 1'b0;
    step("reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(1);
    // lw r5 in EX, add r1,r5,r2 in ID
    step("lu_rs", 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    idle(4);
    step("lu_rt", 1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    idle(4);
    step("r0_load", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    step("rt_unused", 1'b1, 5'd3, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    step("mc_issue", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(5);
    step("beq_lu", 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    idle(3);
    step("mc_then_beq", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("beq_in_mc", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    idle(3);
    // dut_b enters LU_STALL with its countdown at 1, then reset hits mid-stall
    step("lu_pre_rst", 1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    step("rst_mid_lu", 1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    idle(2);
    for (int k = 0; k < 20; k++) step("sat", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(2);
    check_val("sat_sticks_15", 32'(ifb.stall_cnt), 32'd15);
    for (int k = 0; k < 600; k++) begin
      step("rand", ($urandom_range(0, 149) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 6) == 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
